// File: rtl/ex_mem_pkg.sv
// -----------------------------------------------------------------------------
// ex_mem_pkg
// Shared definitions for the EX/MEM pipeline register: bus widths, named
// constants (zero words, NOP register/op, enable levels, stall-bit positions)
// and the packed record that the register stores.
// -----------------------------------------------------------------------------
package ex_mem_pkg;

    // Bus widths
    localparam int REG_ADDR_BUS_W    = 5;
    localparam int REG_BUS_W         = 32;
    localparam int ALU_OP_BUS_W      = 8;
    localparam int INST_BUS_W        = 32;
    localparam int INST_ADDR_BUS_W   = 32;
    localparam int DOUBLE_REG_BUS_W  = 64;
    localparam int STALL_W           = 6;
    localparam int CNT_W             = 2;

    // Stall vector bit positions
    localparam int STALL_EX_BIT      = 3;
    localparam int STALL_MEM_BIT     = 4;

    // Named levels and constants
    localparam logic RST_ENABLE      = 1'b1;
    localparam logic WRITE_ENABLE    = 1'b1;
    localparam logic WRITE_DISABLE   = 1'b0;
    localparam logic STOP            = 1'b1;
    localparam logic NO_STOP         = 1'b0;

    localparam logic [REG_BUS_W-1:0]        ZERO_WORD    = '0;
    localparam logic [DOUBLE_REG_BUS_W-1:0] ZERO_DWORD   = '0;
    localparam logic [CNT_W-1:0]            ZERO_CNT     = '0;
    localparam logic [REG_ADDR_BUS_W-1:0]   NOP_REG_ADDR = '0;
    localparam logic [ALU_OP_BUS_W-1:0]     EXE_NOP_OP   = '0;

    // Everything the EX/MEM register holds, in one record
    typedef struct packed {
        logic [REG_ADDR_BUS_W-1:0]   waddr;
        logic                        reg_we;
        logic [REG_BUS_W-1:0]        alu_res;
        logic                        hi_we;
        logic                        lo_we;
        logic [REG_BUS_W-1:0]        hi;
        logic [REG_BUS_W-1:0]        lo;
        logic [ALU_OP_BUS_W-1:0]     aluop;
        logic [REG_BUS_W-1:0]        mem_addr;
        logic [REG_BUS_W-1:0]        reg2_data;
        logic [INST_BUS_W-1:0]       inst;
        logic [DOUBLE_REG_BUS_W-1:0] hilo;
        logic [CNT_W-1:0]            cnt;
    } ex_mem_stage_t;

    // Idle/NOP contents: used both at reset and as the bubble payload base
    localparam ex_mem_stage_t STAGE_IDLE = '{
        waddr:     NOP_REG_ADDR,
        reg_we:    WRITE_DISABLE,
        alu_res:   ZERO_WORD,
        hi_we:     WRITE_DISABLE,
        lo_we:     WRITE_DISABLE,
        hi:        ZERO_WORD,
        lo:        ZERO_WORD,
        aluop:     EXE_NOP_OP,
        mem_addr:  ZERO_WORD,
        reg2_data: ZERO_WORD,
        inst:      ZERO_WORD,
        hilo:      ZERO_DWORD,
        cnt:       ZERO_CNT
    };

endpackage : ex_mem_pkg

// File: rtl/ex_mem.sv
// -----------------------------------------------------------------------------
// ex_mem
// EX/MEM pipeline register. Three modes selected by the stall vector:
//   ADVANCE (EX not stalled, or the illegal EX-running/MEM-stalled combination):
//           mem_* capture ex_*, hilo_o/cnt_o clear.
//   BUBBLE  (EX stalled, MEM running): mem_* become a NOP, hilo_o/cnt_o
//           capture the MADD/MSUB partial product and count from EX.
//   HOLD    (EX and MEM stalled): every output keeps its value.
// Synchronous active-high reset clears everything and beats HOLD.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   stall[5:0]                    pipeline stall vector (bit3 EX, bit4 MEM)
//   ex_*                          EX-stage results to be registered
//   hilo_i[63:0], cnt_i[1:0]      EX multi-cycle partial product / count
//   mem_*                         registered copies feeding the MEM stage
//   hilo_o[63:0], cnt_o[1:0]      partial product / count returned to EX
// -----------------------------------------------------------------------------
module ex_mem
    import ex_mem_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic [STALL_W-1:0]          stall,

    input  logic [REG_ADDR_BUS_W-1:0]   ex_waddr,
    input  logic                        ex_reg_we,
    input  logic [REG_BUS_W-1:0]        ex_alu_res,
    input  logic                        ex_hi_we,
    input  logic                        ex_lo_we,
    input  logic [REG_BUS_W-1:0]        ex_hi,
    input  logic [REG_BUS_W-1:0]        ex_lo,
    input  logic [ALU_OP_BUS_W-1:0]     ex_aluop,
    input  logic [REG_BUS_W-1:0]        ex_mem_addr,
    input  logic [REG_BUS_W-1:0]        ex_reg2_data,
    input  logic [INST_BUS_W-1:0]       ex_inst,
    input  logic [DOUBLE_REG_BUS_W-1:0] hilo_i,
    input  logic [CNT_W-1:0]            cnt_i,

    output logic [REG_ADDR_BUS_W-1:0]   mem_waddr,
    output logic                        mem_reg_we,
    output logic [REG_BUS_W-1:0]        mem_alu_res,
    output logic                        mem_hi_we,
    output logic                        mem_lo_we,
    output logic [REG_BUS_W-1:0]        mem_hi,
    output logic [REG_BUS_W-1:0]        mem_lo,
    output logic [ALU_OP_BUS_W-1:0]     mem_aluop,
    output logic [REG_BUS_W-1:0]        mem_mem_addr,
    output logic [REG_BUS_W-1:0]        mem_reg2_data,
    output logic [INST_BUS_W-1:0]       mem_inst,
    output logic [DOUBLE_REG_BUS_W-1:0] hilo_o,
    output logic [CNT_W-1:0]            cnt_o
);

    ex_mem_stage_t stage_q;
    ex_mem_stage_t advance_d;
    ex_mem_stage_t bubble_d;

    // Candidate next values for the two loading modes
    always_comb begin
        // NOTE: every always_comb target gets a full default up front so no
        // path can leave it unassigned and infer a latch.
        advance_d = '{
            waddr:     ex_waddr,
            reg_we:    ex_reg_we,
            alu_res:   ex_alu_res,
            hi_we:     ex_hi_we,
            lo_we:     ex_lo_we,
            hi:        ex_hi,
            lo:        ex_lo,
            aluop:     ex_aluop,
            mem_addr:  ex_mem_addr,
            reg2_data: ex_reg2_data,
            inst:      ex_inst,
            // A completed MADD/MSUB must never see a stale partial product
            hilo:      ZERO_DWORD,
            cnt:       ZERO_CNT
        };

        bubble_d      = STAGE_IDLE;
        bubble_d.hilo = hilo_i;
        bubble_d.cnt  = cnt_i;
    end

    // Priority: reset > advance > bubble > hold (no assignment = hold)
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst == RST_ENABLE) begin
            stage_q <= STAGE_IDLE;
        end else if (stall[STALL_EX_BIT] == NO_STOP) begin
            // Also covers the illegal EX-running/MEM-stalled case
            stage_q <= advance_d;
        end else if (stall[STALL_MEM_BIT] == NO_STOP) begin
            stage_q <= bubble_d;
        end
    end

    assign mem_waddr     = stage_q.waddr;
    assign mem_reg_we    = stage_q.reg_we;
    assign mem_alu_res   = stage_q.alu_res;
    assign mem_hi_we     = stage_q.hi_we;
    assign mem_lo_we     = stage_q.lo_we;
    assign mem_hi        = stage_q.hi;
    assign mem_lo        = stage_q.lo;
    assign mem_aluop     = stage_q.aluop;
    assign mem_mem_addr  = stage_q.mem_addr;
    assign mem_reg2_data = stage_q.reg2_data;
    assign mem_inst      = stage_q.inst;
    assign hilo_o        = stage_q.hilo;
    assign cnt_o         = stage_q.cnt;

endmodule : ex_mem

// File: tb/tb_ex_mem.sv
// -----------------------------------------------------------------------------
// tb_ex_mem
// Self-checking bench for ex_mem: a directed vector table covering reset,
// pass-through, bubble, hold, reset during MADD and back-to-back advance,
// followed by randomized cycles checked against a mode-rule reference model.
// -----------------------------------------------------------------------------
module tb_ex_mem;

    typedef struct packed {
        logic [4:0]  waddr;
        logic        reg_we;
        logic [31:0] alu_res;
        logic        hi_we;
        logic        lo_we;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [7:0]  aluop;
        logic [31:0] mem_addr;
        logic [31:0] reg2_data;
        logic [31:0] inst;
        logic [63:0] hilo;
        logic [1:0]  cnt;
    } in_t;

    typedef struct packed {
        logic [4:0]  waddr;
        logic        reg_we;
        logic [31:0] alu_res;
        logic        hi_we;
        logic        lo_we;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [7:0]  aluop;
        logic [31:0] mem_addr;
        logic [31:0] reg2_data;
        logic [31:0] inst;
        logic [63:0] hilo;
        logic [1:0]  cnt;
    } out_t;

    typedef struct {
        string      name;
        bit         rst;
        logic [5:0] stall;
        in_t        din;
        out_t       exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    in_t         din;

    logic [4:0]  mem_waddr;
    logic        mem_reg_we;
    logic [31:0] mem_alu_res;
    logic        mem_hi_we;
    logic        mem_lo_we;
    logic [31:0] mem_hi;
    logic [31:0] mem_lo;
    logic [7:0]  mem_aluop;
    logic [31:0] mem_mem_addr;
    logic [31:0] mem_reg2_data;
    logic [31:0] mem_inst;
    logic [63:0] hilo_o;
    logic [1:0]  cnt_o;
    out_t        dout;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ex_mem dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .ex_waddr      (din.waddr),
        .ex_reg_we     (din.reg_we),
        .ex_alu_res    (din.alu_res),
        .ex_hi_we      (din.hi_we),
        .ex_lo_we      (din.lo_we),
        .ex_hi         (din.hi),
        .ex_lo         (din.lo),
        .ex_aluop      (din.aluop),
        .ex_mem_addr   (din.mem_addr),
        .ex_reg2_data  (din.reg2_data),
        .ex_inst       (din.inst),
        .hilo_i        (din.hilo),
        .cnt_i         (din.cnt),
        .mem_waddr     (mem_waddr),
        .mem_reg_we    (mem_reg_we),
        .mem_alu_res   (mem_alu_res),
        .mem_hi_we     (mem_hi_we),
        .mem_lo_we     (mem_lo_we),
        .mem_hi        (mem_hi),
        .mem_lo        (mem_lo),
        .mem_aluop     (mem_aluop),
        .mem_mem_addr  (mem_mem_addr),
        .mem_reg2_data (mem_reg2_data),
        .mem_inst      (mem_inst),
        .hilo_o        (hilo_o),
        .cnt_o         (cnt_o)
    );

    assign dout = {mem_waddr, mem_reg_we, mem_alu_res, mem_hi_we, mem_lo_we,
                   mem_hi, mem_lo, mem_aluop, mem_mem_addr, mem_reg2_data,
                   mem_inst, hilo_o, cnt_o};

    task automatic check(input string name, input out_t act, input out_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Distinct, recognisable contents for every field from one seed word
    function automatic in_t seed_in(input logic [31:0] s);
        in_t i;
        i.waddr     = s[4:0];
        i.reg_we    = s[0];
        i.alu_res   = s;
        i.hi_we     = s[1];
        i.lo_we     = s[2];
        i.hi        = ~s;
        i.lo        = s ^ 32'h5A5A_5A5A;
        i.aluop     = s[7:0];
        i.mem_addr  = {s[15:0], s[31:16]};
        i.reg2_data = s ^ 32'hFFFF_0000;
        i.inst      = s;
        i.hilo      = {s, ~s};
        i.cnt       = s[1:0];
        return i;
    endfunction

    function automatic in_t rand_in();
        in_t i;
        i.waddr     = 5'($urandom);
        i.reg_we    = 1'($urandom);
        i.alu_res   = $urandom;
        i.hi_we     = 1'($urandom);
        i.lo_we     = 1'($urandom);
        i.hi        = $urandom;
        i.lo        = $urandom;
        i.aluop     = 8'($urandom);
        i.mem_addr  = $urandom;
        i.reg2_data = $urandom;
        i.inst      = $urandom;
        i.hilo      = {$urandom, $urandom};
        i.cnt       = 2'($urandom);
        return i;
    endfunction

    // Reference model: what the register shows after one edge, derived from
    // the mode rules (reset wins; EX running means copy; EX stalled with MEM
    // running means a NOP carrying the partial product; both stalled = keep).
    typedef enum {M_RESET, M_ADVANCE, M_BUBBLE, M_HOLD} mode_e;

    function automatic out_t model(input out_t cur, input bit r,
                                   input logic [5:0] st, input in_t i);
        mode_e m;
        out_t  n;
        if (r)              m = M_RESET;
        else if (!st[3])    m = M_ADVANCE;
        else if (!st[4])    m = M_BUBBLE;
        else                m = M_HOLD;
        n = '0;
        case (m)
            M_ADVANCE: begin
                n = out_t'(i);
                n.hilo = '0;
                n.cnt  = '0;
            end
            M_BUBBLE: begin
                n.hilo = i.hilo;
                n.cnt  = i.cnt;
            end
            M_HOLD:  n = cur;
            default: n = '0;
        endcase
        return n;
    endfunction

    vec_t vecs[$];

    task automatic add(input string name, input bit r, input logic [5:0] st,
                       input in_t i, input out_t e);
        vec_t v;
        v.name  = name;
        v.rst   = r;
        v.stall = st;
        v.din   = i;
        v.exp   = e;
        vecs.push_back(v);
    endtask

    initial begin
        in_t  i;
        out_t e;
        out_t held;
        out_t exp_state;

        rst   = 1'b1;
        stall = '0;
        din   = '1;

        // Reset with all inputs high, any stall
        add("reset_0", 1'b1, 6'b000000, '1, '0);
        add("reset_1", 1'b1, 6'b111111, '1, '0);

        // Pass-through
        i = '0; i.waddr = 5'd5; i.reg_we = 1'b1; i.alu_res = 32'h1234_5678;
        e = '0; e.waddr = 5'd5; e.reg_we = 1'b1; e.alu_res = 32'h1234_5678;
        add("pass_through", 1'b0, 6'b000000, i, e);

        // Bubble returns the partial product, next advance clears the count
        i = '1; i.hilo = 64'h0000_0001_8000_0000; i.cnt = 2'd1;
        e = '0; e.hilo = 64'h0000_0001_8000_0000; e.cnt = 2'd1;
        add("bubble", 1'b0, 6'b001111, i, e);
        i = '0; i.alu_res = 32'hA5A5_A5A5; i.hilo = '1; i.cnt = 2'd3;
        e = '0; e.alu_res = 32'hA5A5_A5A5;
        add("bubble_then_advance", 1'b0, 6'b000000, i, e);

        // Hold for 3 cycles while inputs change
        held = e;
        add("hold_0", 1'b0, 6'b011111, '1, held);
        add("hold_1", 1'b0, 6'b011111, seed_in(32'h0BAD_F00D), held);
        add("hold_2", 1'b0, 6'b011111, seed_in(32'h7777_1234), held);

        // Reset in the middle of MADD: bubble, hold, then reset under hold
        i = seed_in(32'hCAFE_0001); i.hilo = 64'hDEAD_BEEF_0000_0001; i.cnt = 2'd1;
        e = '0; e.hilo = 64'hDEAD_BEEF_0000_0001; e.cnt = 2'd1;
        add("madd_bubble", 1'b0, 6'b001111, i, e);
        add("madd_hold", 1'b0, 6'b011111, '1, e);
        add("madd_reset", 1'b1, 6'b011111, '1, '0);

        // First advance after reset, then back-to-back distinct instructions
        i = seed_in(32'h1111_1111); e = out_t'(i); e.hilo = '0; e.cnt = '0;
        add("post_reset_adv", 1'b0, 6'b000000, i, e);
        i = seed_in(32'h2222_2222); e = out_t'(i); e.hilo = '0; e.cnt = '0;
        add("b2b_1", 1'b0, 6'b000000, i, e);
        i = seed_in(32'h3333_3333); e = out_t'(i); e.hilo = '0; e.cnt = '0;
        add("b2b_2", 1'b0, 6'b000000, i, e);
        i = seed_in(32'h4444_4444); e = out_t'(i); e.hilo = '0; e.cnt = '0;
        add("b2b_3", 1'b0, 6'b000000, i, e);

        // Illegal EX-running/MEM-stalled behaves as advance
        i = seed_in(32'h9876_5432); e = out_t'(i); e.hilo = '0; e.cnt = '0;
        add("illegal_stall", 1'b0, 6'b010000, i, e);

        foreach (vecs[k]) begin
            rst   = vecs[k].rst;
            stall = vecs[k].stall;
            din   = vecs[k].din;
            @(posedge clk);
            #1;
            check(vecs[k].name, dout, vecs[k].exp);
        end
        exp_state = vecs[vecs.size()-1].exp;

        // Randomized cycles against the reference model
        for (int k = 0; k < 400; k++) begin
            bit         r;
            logic [5:0] st;
            r = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 4))
                0:       st = 6'b000000;
                1:       st = 6'b001111;
                2:       st = 6'b011111;
                3:       st = 6'b010000;
                default: st = 6'($urandom);
            endcase
            rst   = r;
            stall = st;
            din   = rand_in();
            #1;
            // Outputs must not follow inputs between edges
            check($sformatf("no_comb_path[%0d]", k), dout, exp_state);
            @(posedge clk);
            #1;
            exp_state = model(exp_state, r, st, din);
            check($sformatf("random[%0d]", k), dout, exp_state);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule : tb_ex_mem

// File: doc/ex_mem.md
EX_MEM -- requirements
Module: ex_mem

Interface
REQ-001 SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-002 SHALL have port rst, input, 1, reset, synchronous, active-high.
REQ-003 SHALL have port stall, input, 6, pipeline stall vector: bit3 = EX stalled, bit4 = MEM stalled.
REQ-004 SHALL have inputs ex_waddr (5), ex_reg_we (1), ex_alu_res (32): EX-stage destination register, write enable and ALU result.
REQ-005 SHALL have inputs ex_hi_we (1), ex_lo_we (1), ex_hi (32), ex_lo (32): EX-stage HI/LO write enables and data.
REQ-006 SHALL have inputs ex_aluop (8), ex_mem_addr (32), ex_reg2_data (32), ex_inst (32): load/store op code, effective address, store data and debug instruction word.
REQ-007 SHALL have inputs hilo_i (64) and cnt_i (2): EX multi-cycle MADD/MSUB partial product and cycle count.
REQ-008 SHALL have outputs mem_waddr, mem_reg_we, mem_alu_res, mem_hi_we, mem_lo_we, mem_hi, mem_lo, mem_aluop, mem_mem_addr, mem_reg2_data, mem_inst: registered copies of REQ-004..006, same widths, feeding the MEM stage.
REQ-009 SHALL have outputs hilo_o (64) and cnt_o (2): partial product and count returned to EX.

Function
REQ-010 All outputs SHALL be registers updated only on the rising edge of clk; there SHALL be no combinational input-to-output path.
REQ-011 Mode ADVANCE: when stall[3]=0, all mem_* SHALL capture the matching ex_* inputs, and hilo_o and cnt_o SHALL clear to 0.
REQ-012 Mode BUBBLE: when stall[3]=1 and stall[4]=0, mem_reg_we, mem_hi_we and mem_lo_we SHALL be 0; mem_waddr SHALL be 0 (NOP register); mem_aluop SHALL be NOP (0); all other mem_* SHALL be 0.
REQ-013 In BUBBLE, hilo_o SHALL capture hilo_i and cnt_o SHALL capture cnt_i.
REQ-014 Mode HOLD: when stall[3]=1 and stall[4]=1, every output, including hilo_o and cnt_o, SHALL retain its value.
REQ-015 stall[3]=0 with stall[4]=1 is illegal; the block SHALL treat it as ADVANCE.
REQ-016 Latency SHALL be exactly 1 cycle from an ex_* value to the matching mem_* value in ADVANCE.
REQ-017 The multi-cycle handshake SHALL work as follows:
- EX asserts the stall request with cnt_i=1 and a valid hilo_i.
- One BUBBLE cycle returns them on hilo_o/cnt_o.
- The next ADVANCE clears cnt_o, so a completed MADD cannot reuse a stale partial product.
REQ-018 The block SHALL do no arithmetic; all data widths SHALL pass through unchanged.

Reset
REQ-019 With rst=1 at a clock edge, every output SHALL become 0 (mem_waddr = NOP register 0, all write enables disabled, mem_aluop = NOP, hilo_o = 0, cnt_o = 0), regardless of stall.
REQ-020 Reset SHALL take priority over HOLD, and a reset in the middle of a multi-cycle MADD/MSUB SHALL discard the partial product.
REQ-021 The first ADVANCE after rst deasserts SHALL load the inputs normally.

Structure
REQ-022 Widths (RegAddrBus 5, RegBus 32, AluOpBus 8, InstBus 32, InstAddrBus 32, DoubleRegBus 64), ZeroWord, NOPRegAddr, WriteEnable/WriteDisable, RstEnable and the NOP aluop code SHALL come from the shared defines file; no literals in the RTL.
REQ-023 The block SHALL be a single flat module with no sub-modules, and the mode selection SHALL be one priority-encoded sequential process.

Verification
REQ-024 Reset: rst=1 for 2 cycles with all inputs 0xFFFFFFFF -> every output reads 0, cnt_o=0.
REQ-025 Pass-through: stall=0, ex_waddr=5, ex_reg_we=1, ex_alu_res=0x12345678 -> the next cycle shows mem_waddr=5, mem_reg_we=1, mem_alu_res=0x12345678, hilo_o=0.
REQ-026 Bubble: stall=6'b001111, cnt_i=1, hilo_i=0x00000001_80000000 -> mem_reg_we=0, mem_waddr=0, hilo_o=0x0000000180000000, cnt_o=1; then stall=0 -> cnt_o=0.
REQ-027 Hold: load mem_alu_res=0xA5A5A5A5, then stall=6'b011111 for 3 cycles while the inputs change -> all outputs stay constant, including hilo_o/cnt_o.
REQ-028 Reset in the middle of MADD: cnt_o=1 after a bubble, then rst=1 while stall=6'b011111 -> hilo_o=0, cnt_o=0 the next cycle.
REQ-029 Back-to-back: 4 consecutive ADVANCE cycles with distinct ex_inst values -> mem_inst follows them with 1-cycle latency and no gaps.
